clock_gate_ctrl: RTL and testbench

- Parametrised multi-channel clock-gating controller.
- Drives NUM_CH gated clocks, each through its own latch-based ICG (prim_clock_gating).
- Each channel has a per-channel mode, activity-driven auto-gating with idle hysteresis, and a wake request/acknowledge handshake for consumers that need a settled clock.
- Sits between the always-on core clock and per-unit clock domains (vector, LSU, debug).

---
 rtl/clock_gate_pkg.sv | 13 +
 rtl/clock_gate_ch.sv | 93 +++++++++
 rtl/prim_clock_gating.sv | 14 +
 rtl/clock_gate_ctrl.sv | 53 +++++
 tb/tb_clock_gate_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_gate_pkg.sv
// clock_gate_pkg: shared modes, channel states and defaults for the clock-gating controller
package clock_gate_pkg;
    typedef enum logic [1:0] {CG_AUTO, CG_FORCE_ON, CG_FORCE_OFF, CG_RSVD} cg_mode_e;
    typedef enum logic [1:0] {CG_OFF, CG_WAKE, CG_ON, CG_IDLE} cg_state_e;
    localparam int CG_IDLE_DEF = 16;
    localparam int CG_WAKE_DEF = 2;
    // width of a down-counter able to hold max(idle, wake), never narrower than 1 bit
    function automatic int cg_cnt_w(input int idle, input int wake);
        int mx;
        mx = idle > wake ? idle : wake;
        return mx > 0 ? $clog2(mx + 1) : 1;
    endfunction
endpackage

// File: rtl/clock_gate_ch.sv
// clock_gate_ch: one gated-clock channel (FSM, hysteresis counter, wake ack, ICG)
//   clk_i/rst_i core clock and async active-high reset, test_en_i scan override,
//   mode_i channel mode, busy_i activity, wake_req_i wake request,
//   wake_ack_o registered acknowledge, en_o ICG enable, clk_o gated clock.
//   CLOCK_GATE_CTRL_STATS_EN adds clr_stats_i and gated_cnt_o (saturating gated-cycle count).
module clock_gate_ch
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = CG_IDLE_DEF,
    parameter int WAKE_CYCLES = CG_WAKE_DEF
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,parameter int STAT_W = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             test_en_i,
    input  logic [1:0]       mode_i,
    input  logic             busy_i,
    input  logic             wake_req_i,
`ifdef CLOCK_GATE_CTRL_STATS_EN
    input  logic             clr_stats_i,
    output logic [STAT_W-1:0] gated_cnt_o,
`endif
    output logic             wake_ack_o,
    output logic             en_o,
    output logic             clk_o
);
    localparam int CW = cg_cnt_w(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CW-1:0] WLD = CW'(WAKE_CYCLES > 0 ? WAKE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ILD = CW'(IDLE_CYCLES > 0 ? IDLE_CYCLES - 1 : 0);

    cg_state_e st, nxt;
    cg_mode_e m;
    logic [CW-1:0] cnt, cnt_n;
    logic act, ack_n;

    assign m   = cg_mode_e'(mode_i);
    // any reason to keep or bring the clock up (FORCE_OFF is handled first)
    assign act = m == CG_FORCE_ON || busy_i || wake_req_i;

    always_comb begin
        nxt   = st;
        cnt_n = cnt;
        if (m == CG_FORCE_OFF)
            nxt = CG_OFF;
        else
            case (st)
                CG_OFF: if (act) begin
                    nxt   = WAKE_CYCLES == 0 ? CG_ON : CG_WAKE;
                    cnt_n = WLD;
                end
                CG_WAKE: if (cnt == '0) nxt = CG_ON;
                         else cnt_n = cnt - CW'(1);
                CG_ON: if (!act) begin
                    nxt   = IDLE_CYCLES == 0 ? CG_OFF : CG_IDLE;
                    cnt_n = ILD;
                end
                default: if (act) nxt = CG_ON;
                         else if (cnt == '0) nxt = CG_OFF;
                         else cnt_n = cnt - CW'(1);
            endcase
        // ack rises with the end of WAKE; a return from IDLE acks one cycle later
        ack_n = wake_req_i && nxt == CG_ON && (st == CG_ON || st == CG_WAKE);
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            st         <= CG_OFF;
            cnt        <= '0;
            wake_ack_o <= 1'b0;
        end else begin
            st         <= nxt;
            cnt        <= cnt_n;
            wake_ack_o <= ack_n;
        end

    assign en_o = st != CG_OFF;

    prim_clock_gating u_icg (
        .clk_i     (clk_i),
        .en_i      (en_o),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

`ifdef CLOCK_GATE_CTRL_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) gated_cnt_o <= '0;
        else gated_cnt_o <= clr_stats_i ? '0 :
                            (!en_o && !(&gated_cnt_o)) ? gated_cnt_o + STAT_W'(1) : gated_cnt_o;
`endif
endmodule

// File: rtl/prim_clock_gating.sv
// prim_clock_gating: latch-based integrated clock gate
//   clk_i in, en_i in (functional enable), test_en_i in (scan override), clk_o out (gated clock)
module prim_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_l;
    // enable is captured while the clock is low so clk_o can never glitch
    always_latch
        if (!clk_i) en_l = en_i | test_en_i;
    assign clk_o = clk_i & en_l;
endmodule

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: NUM_CH-channel clock-gating controller with auto-gating and wake handshake
//   clk_i core clock, rst_i async active-high reset, test_en_i forces all clk_o running,
//   mode_i 2 bits per channel (AUTO/FORCE_ON/FORCE_OFF/AUTO), busy_i and wake_req_i per channel,
//   wake_ack_o, en_o and clk_o per channel.
//   CLOCK_GATE_CTRL_STATS_EN adds clr_stats_i and gated_cnt_o (STAT_W per channel).
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = CG_IDLE_DEF,
    parameter int WAKE_CYCLES = CG_WAKE_DEF
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,parameter int STAT_W = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic [NUM_CH-1:0]     busy_i,
    input  logic [NUM_CH-1:0]     wake_req_i,
`ifdef CLOCK_GATE_CTRL_STATS_EN
    input  logic                  clr_stats_i,
    output logic [STAT_W*NUM_CH-1:0] gated_cnt_o,
`endif
    output logic [NUM_CH-1:0]     wake_ack_o,
    output logic [NUM_CH-1:0]     en_o,
    output logic [NUM_CH-1:0]     clk_o
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_gate_ch #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
`ifdef CLOCK_GATE_CTRL_STATS_EN
            ,.STAT_W     (STAT_W)
`endif
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .test_en_i   (test_en_i),
            .mode_i      (mode_i[2*g+:2]),
            .busy_i      (busy_i[g]),
            .wake_req_i  (wake_req_i[g]),
`ifdef CLOCK_GATE_CTRL_STATS_EN
            .clr_stats_i (clr_stats_i),
            .gated_cnt_o (gated_cnt_o[STAT_W*g+:STAT_W]),
`endif
            .wake_ack_o  (wake_ack_o[g]),
            .en_o        (en_o[g]),
            .clk_o       (clk_o[g])
        );
    end
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: scoreboard bench for clock_gate_ctrl
module tb_clock_gate_ctrl;
    localparam int N  = 4;
    localparam int IC = 16;
    localparam int WC = 2;

    logic clk = 1'b0, rst = 1'b1, test_en = 1'b0;
    logic [2*N-1:0] mode = '0;
    logic [N-1:0] busy = '0, req = '0;
    logic [N-1:0] ack, en, gclk;
`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic clr = 1'b0;
    logic [4*N-1:0] gcnt;
`endif

    always #5 clk = ~clk;

    clock_gate_ctrl #(
        .NUM_CH      (N),
        .IDLE_CYCLES (IC),
        .WAKE_CYCLES (WC)
`ifdef CLOCK_GATE_CTRL_STATS_EN
        ,.STAT_W     (4)
`endif
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .test_en_i   (test_en),
        .mode_i      (mode),
        .busy_i      (busy),
        .wake_req_i  (req),
`ifdef CLOCK_GATE_CTRL_STATS_EN
        .clr_stats_i (clr),
        .gated_cnt_o (gcnt),
`endif
        .wake_ack_o  (ack),
        .en_o        (en),
        .clk_o       (gclk)
    );

    int n_chk = 0, n_fail = 0;
    logic [2*N-1:0] sb[$];
    logic [2*N-1:0] exp;
    // reference: clock running, enabled cycles so far during warm-up, consecutive quiet cycles
    bit active[N];
    int warm[N], quiet[N];
    bit mack[N];

    task automatic model_reset;
        for (int c = 0; c < N; c++) begin
            active[c] = 0; warm[c] = 0; quiet[c] = 0; mack[c] = 0;
        end
        sb.delete();
    endtask

    // advance the reference on the inputs now applied, queue its prediction, then clock the DUT
    task automatic tick;
        logic [N-1:0] e, a;
        for (int c = 0; c < N; c++) begin
            logic [1:0] md;
            bit fo, act;
            md  = mode[2*c+:2];
            fo  = md == 2'd2;
            act = md == 2'd1 || busy[c] || req[c];
            if (fo) begin
                active[c] = 0; mack[c] = 0;
            end else if (!active[c]) begin
                if (act) begin
                    active[c] = 1; warm[c] = WC == 0 ? WC + 1 : 1; quiet[c] = 0;
                end
                mack[c] = 0;
            end else if (warm[c] <= WC) begin
                mack[c] = warm[c] == WC && req[c];
                warm[c]++;
            end else if (quiet[c] == 0) begin
                if (act) mack[c] = req[c];
                else begin
                    mack[c] = 0;
                    if (IC == 0) active[c] = 0; else quiet[c] = 1;
                end
            end else begin
                mack[c] = 0;
                if (act) quiet[c] = 0;
                else if (quiet[c] == IC) active[c] = 0;
                else quiet[c]++;
            end
            e[c] = active[c];
            a[c] = mack[c];
        end
        sb.push_back({e, a});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; busy = '0; req = '0; mode = '0; test_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (en !== '0 || ack !== '0 || gclk !== '0) begin
            n_fail++;
            $display("FAIL reset_state en=%b ack=%b clk_o=%b required 0/0/0", en, ack, gclk);
        end
        test_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (gclk !== '1 || en !== '0) begin
            n_fail++;
            $display("FAIL test_en_high clk_o=%b en=%b required 1111/0000", gclk, en);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (gclk !== '0) begin
            n_fail++;
            $display("FAIL test_en_low_phase clk_o=%b required 0000", gclk);
        end
        @(posedge clk);
        #1;
        test_en = 1'b0;
        rst = 1'b0;
        model_reset();
        for (int n = 1; n <= 6; n++) begin
            tick();
            exp = sb.pop_front();
            n_chk++;
            if ({en, ack} !== exp || (n > 1 && gclk !== '0)) begin
                n_fail++;
                $display("FAIL idle_after_reset n=%0d en/ack=%b clk_o=%b required %b/0000", n, {en, ack}, gclk, exp);
            end
        end
    endtask

    task automatic test_wake_handshake;
        do_reset();
        req[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            if (n == 6) req[0] = 1'b0;
            tick();
            exp = sb.pop_front();
            n_chk++;
            if ({en, ack} !== exp) begin
                n_fail++;
                $display("FAIL wake_sb n=%0d en/ack=%b required %b", n, {en, ack}, exp);
            end
            n_chk++;
            if (en[0] !== 1'b1 || ack[0] !== (n >= 3 && n <= 5)) begin
                n_fail++;
                $display("FAIL wake_timing n=%0d en0=%b ack0=%b required 1/%0d", n, en[0], ack[0], n >= 3 && n <= 5);
            end
        end
    endtask

    task automatic test_idle_hysteresis;
        for (int r = 0; r < 2; r++) begin
            int fall;
            fall = r ? 38 : 27;
            do_reset();
            busy[1] = 1'b1;
            for (int n = 1; n <= 40; n++) begin
                if (n == 11) busy[1] = 1'b0;
                if (r == 1 && n == 21) busy[1] = 1'b1;
                if (r == 1 && n == 22) busy[1] = 1'b0;
                tick();
                exp = sb.pop_front();
                n_chk++;
                if ({en, ack} !== exp) begin
                    n_fail++;
                    $display("FAIL idle_sb r=%0d n=%0d en/ack=%b required %b", r, n, {en, ack}, exp);
                end
                n_chk++;
                if (en[1] !== (n < fall)) begin
                    n_fail++;
                    $display("FAIL idle_fall r=%0d n=%0d en1=%b required %0d", r, n, en[1], n < fall);
                end
            end
        end
    endtask

    task automatic test_force_modes;
        do_reset();
        mode[5:4] = 2'd1;
        for (int n = 1; n <= 36; n++) begin
            if (n == 11) req[2] = 1'b1;
            if (n == 31) mode[5:4] = 2'd2;
            tick();
            exp = sb.pop_front();
            n_chk++;
            if ({en, ack} !== exp) begin
                n_fail++;
                $display("FAIL force_sb n=%0d en/ack=%b required %b", n, {en, ack}, exp);
            end
            n_chk++;
            if (en[2] !== (n <= 30) || ack[2] !== (n >= 11 && n <= 30)) begin
                n_fail++;
                $display("FAIL force_ch2 n=%0d en2=%b ack2=%b required %0d/%0d", n, en[2], ack[2], n <= 30, n >= 11 && n <= 30);
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [N-1:0] prev;
            if (n == 300) begin
                @(negedge clk);
                #1;
                rst = 1'b1;
                #1;
                n_chk++;
                if (en !== '0 || ack !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset en=%b ack=%b required 0000/0000", en, ack);
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
                req = '0;
                model_reset();
            end
            for (int c = 0; c < N; c++) begin
                busy[c] = $urandom_range(0, 99) < ((((n / 50) + c) % 4 == 0) ? 60 : 2);
                if (!req[c] && $urandom_range(0, 29) == 0) req[c] = 1'b1;
                else if (req[c] && ack[c] && $urandom_range(0, 2) == 0) req[c] = 1'b0;
                if ($urandom_range(0, 79) == 0) mode[2*c+:2] = 2'($urandom_range(0, 3));
                else if ($urandom_range(0, 19) == 0) mode[2*c+:2] = 2'd0;
            end
            test_en = $urandom_range(0, 7) == 0;
            prev = en | {N{test_en}};
            tick();
            exp = sb.pop_front();
            n_chk++;
            if ({en, ack} !== exp || gclk !== prev) begin
                n_fail++;
                $display("FAIL b2b n=%0d en/ack=%b clk_o=%b required %b clk_o=%b", n, {en, ack}, gclk, exp, prev);
            end
        end
        test_en = 1'b0;
    endtask

`ifdef CLOCK_GATE_CTRL_STATS_EN
    task automatic test_stats;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        n_chk++;
        if (gcnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_saturate cnt=%h required ffff", gcnt);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_chk++;
        if (gcnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL stats_clear cnt=%h required 0000", gcnt);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (gcnt !== 16'h1111) begin
            n_fail++;
            $display("FAIL stats_count cnt=%h required 1111", gcnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wake_handshake();
        test_idle_hysteresis();
        test_force_modes();
        test_back_to_back();
`ifdef CLOCK_GATE_CTRL_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks=%0d", n_chk);
        $fatal(1, "timeout");
    end
endmodule
